// File: rtl/bp_dma_mem_responder_if.sv
// DMA bus between a bsg_cache_dma master and bp_dma_mem_responder.
// Signal names keep the responder's point of view (_i into it, _o out of it).
interface bp_dma_mem_responder_if #(
  parameter int addr_width_p = 28,
  parameter int data_width_p = 64
);
  logic [addr_width_p:0]   dma_pkt_i;
  logic                    dma_pkt_v_i;
  logic                    dma_pkt_yumi_o;
  logic [data_width_p-1:0] dma_data_o;
  logic                    dma_data_v_o;
  logic                    dma_data_ready_and_i;
  logic [data_width_p-1:0] dma_data_i;
  logic                    dma_data_v_i;
  logic                    dma_data_yumi_o;

  modport master (
    output dma_pkt_i, dma_pkt_v_i, dma_data_ready_and_i, dma_data_i, dma_data_v_i,
    input  dma_pkt_yumi_o, dma_data_o, dma_data_v_o, dma_data_yumi_o
  );

  modport slave (
    input  dma_pkt_i, dma_pkt_v_i, dma_data_ready_and_i, dma_data_i, dma_data_v_i,
    output dma_pkt_yumi_o, dma_data_o, dma_data_v_o, dma_data_yumi_o
  );
endinterface

// File: rtl/bp_dma_mem_responder.sv
// Simulation DRAM stand-in serving one bsg_cache_dma packet at a time from a word array.
// Optional macro BP_DMA_MEM_DELAY_EN inserts latency_p cycles between packet accept and data.
module bp_dma_mem_responder #(
  parameter int addr_width_p = 28,
  parameter int data_width_p = 64,
  parameter int burst_len_p  = 8,
  parameter int mem_els_p    = 1024,
  parameter int latency_p    = 4
) (
  input logic clk_i,
  input logic reset_i,
  bp_dma_mem_responder_if.slave dma_if
);

  localparam int byte_offset_lp = $clog2(data_width_p / 8);
  localparam int cnt_width_lp   = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
  localparam int idx_width_lp   = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
  localparam logic [idx_width_lp-1:0] burst_mask_lp = idx_width_lp'(burst_len_p - 1);
  localparam logic [cnt_width_lp-1:0] last_beat_lp  = cnt_width_lp'(burst_len_p - 1);

`ifdef BP_DMA_MEM_DELAY_EN
  localparam int dly_width_lp = (latency_p > 1) ? $clog2(latency_p) : 1;
  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_read  = 2'd1,
    e_write = 2'd2,
    e_delay = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_read  = 2'd1,
    e_write = 2'd2
  } state_e;
`endif

  state_e                  state_r, state_n;
  logic                    pkt_wnr_r, pkt_wnr_n;
  logic [idx_width_lp-1:0] pkt_base_r, pkt_base_n;
  logic [cnt_width_lp-1:0] cnt_r, cnt_n;
`ifdef BP_DMA_MEM_DELAY_EN
  logic [dly_width_lp-1:0] dly_r, dly_n;
`endif

  logic                    pkt_yumi;
  logic                    data_v;
  logic                    data_yumi;
  logic                    mem_we;
  logic [idx_width_lp-1:0] pkt_word_idx;
  logic [idx_width_lp-1:0] entry;

  // Upper address bits fall off in the truncation, so addresses alias modulo the array.
  assign pkt_word_idx = idx_width_lp'(dma_if.dma_pkt_i[addr_width_p-1:0] >> byte_offset_lp);
  assign entry        = pkt_base_r + idx_width_lp'(cnt_r);

  logic [data_width_p-1:0] mem_r [mem_els_p];

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_r[entry] <= dma_if.dma_data_i;
    end
  end

  always_comb begin
    state_n    = state_r;
    pkt_wnr_n  = pkt_wnr_r;
    pkt_base_n = pkt_base_r;
    cnt_n      = cnt_r;
`ifdef BP_DMA_MEM_DELAY_EN
    dly_n      = dly_r;
`endif
    pkt_yumi   = 1'b0;
    data_v     = 1'b0;
    data_yumi  = 1'b0;
    mem_we     = 1'b0;

    // Reset gates every output so a burst cut off by reset neither transfers nor writes.
    if (!reset_i) begin
      unique case (state_r)
        e_ready: begin
          pkt_yumi = dma_if.dma_pkt_v_i;
          if (pkt_yumi) begin
            pkt_wnr_n  = dma_if.dma_pkt_i[addr_width_p];
            pkt_base_n = pkt_word_idx & ~burst_mask_lp;
            cnt_n      = '0;
`ifdef BP_DMA_MEM_DELAY_EN
            dly_n      = dly_width_lp'(latency_p - 1);
            state_n    = e_delay;
`else
            state_n    = dma_if.dma_pkt_i[addr_width_p] ? e_write : e_read;
`endif
          end
        end

`ifdef BP_DMA_MEM_DELAY_EN
        e_delay: begin
          if (dly_r == '0) begin
            state_n = pkt_wnr_r ? e_write : e_read;
          end else begin
            dly_n = dly_r - 1'b1;
          end
        end
`endif

        e_read: begin
          data_v = 1'b1;
          if (dma_if.dma_data_ready_and_i) begin
            if (cnt_r == last_beat_lp) begin
              cnt_n   = '0;
              state_n = e_ready;
            end else begin
              cnt_n = cnt_r + 1'b1;
            end
          end
        end

        e_write: begin
          data_yumi = dma_if.dma_data_v_i;
          mem_we    = data_yumi;
          if (data_yumi) begin
            if (cnt_r == last_beat_lp) begin
              cnt_n   = '0;
              state_n = e_ready;
            end else begin
              cnt_n = cnt_r + 1'b1;
            end
          end
        end

        default: state_n = e_ready;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_ready;
      cnt_r   <= '0;
`ifdef BP_DMA_MEM_DELAY_EN
      dly_r   <= '0;
`endif
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
`ifdef BP_DMA_MEM_DELAY_EN
      dly_r   <= dly_n;
`endif
    end
    pkt_wnr_r  <= pkt_wnr_n;
    pkt_base_r <= pkt_base_n;
  end

  assign dma_if.dma_pkt_yumi_o  = pkt_yumi;
  assign dma_if.dma_data_v_o    = data_v;
  assign dma_if.dma_data_o      = mem_r[entry];
  assign dma_if.dma_data_yumi_o = data_yumi;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i && dma_if.dma_pkt_v_i) begin
      assert (!$isunknown(dma_if.dma_pkt_i[addr_width_p]))
        else $error("bp_dma_mem_responder: packet with unknown write_not_read bit");
    end
    if (reset_i) begin
      assert (latency_p >= 1 && burst_len_p >= 1 && mem_els_p >= burst_len_p
              && (data_width_p % 8) == 0)
        else $error("bp_dma_mem_responder: illegal parameterisation");
    end
  end
`endif

endmodule

// File: doc/bp_dma_mem_responder.md
Name: bp_dma_mem_responder

Overview:
- Target end of the bsg_cache_dma interface that the tethered test wrapper exposes per CCE (dma_pkt / dma_data in / dma_data out).
- Accepts one DMA packet at a time and serves it from an internal word-addressed memory array.
  - Read: streams burst_len_p fill beats back.
  - Write: consumes burst_len_p fill beats.
- One instance per CCE; simulation DRAM stand-in.

Parameters:
- addr_width_p, 28, DMA packet address width (caddr).
- data_width_p, 64, fill beat width (l2_fill_width); multiple of 8.
- burst_len_p, 8, beats per packet (l2_block_size_in_fill); power of 2, ≥1.
- mem_els_p, 1024, memory depth in data_width_p words; power of 2, ≥ burst_len_p.
- latency_p, 4, added cycles before first beat; used only with BP_DMA_MEM_DELAY_EN; ≥1.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- dma_pkt_i  in  addr_width_p+1  packet; MSB = write_not_read, low addr_width_p bits = byte address.
- dma_pkt_v_i  in  1  packet valid.
- dma_pkt_yumi_o  out  1  packet consumed this cycle.
- dma_data_o  out  data_width_p  read fill beat.
- dma_data_v_o  out  1  read beat valid.
- dma_data_ready_and_i  in  1  consumer ready; beat transfers when v & ready.
- dma_data_i  in  data_width_p  write fill beat.
- dma_data_v_i  in  1  write beat valid.
- dma_data_yumi_o  out  1  write beat consumed this cycle.

Behaviour:
- Handshakes:
  - Packet port: valid/yumi; yumi_o only when v_i = 1.
  - Read data: valid/ready_and; v_o must not drop and data_o must not change while ready = 0.
  - Write data: valid/yumi.
- Address:
  - Word index = addr >> log2(data_width_p/8).
  - Base = word index with low log2(burst_len_p) bits cleared.
  - Beat k uses entry (base + k) mod mem_els_p; upper address bits are ignored (aliasing).
- Storage:
  - mem_els_p × data_width_p array, combinational read, write on clock edge.
  - Contents are not reset and are preserved across reset_i.
- Registers: pkt_r (write_not_read, base), beat counter cnt_r (width = safe clog2(burst_len_p)).
- FSM states: e_ready, e_delay (feature only), e_read, e_write.
- e_ready:
  - dma_pkt_yumi_o = dma_pkt_v_i.
  - On yumi: latch pkt_r, cnt_r ← 0, next state = e_read or e_write per write_not_read (e_delay with feature).
- e_read:
  - dma_data_v_o = 1, dma_data_o = mem[base + cnt_r].
  - On v & ready: cnt_r++. On the last beat (cnt_r = burst_len_p-1), go to e_ready.
- e_write:
  - dma_data_yumi_o = dma_data_v_i; on yumi, mem[base + cnt_r] ← dma_data_i and cnt_r++.
  - On the last beat, go to e_ready.
- Latency (no feature):
  - Read: first beat valid in the cycle after the packet yumi.
  - Write: beats consumable from the cycle after the packet yumi.
- Back-to-back: the next packet is accepted no earlier than the cycle after the last beat of the previous packet.
- Gating:
  - Write beats presented outside e_write are not consumed (yumi_o = 0).
  - dma_data_v_o = 0 outside e_read.
  - dma_pkt_yumi_o = 0 outside e_ready.
- burst_len_p = 1: a single beat; counter is held at 0.
- Reset (also mid-burst):
  - State → e_ready, cnt_r → 0.
  - All outputs 0 in the reset cycle; dma_data_o value is don't-care while v_o = 0.
  - Any in-flight burst is abandoned; memory writes already done remain.
- Assertions (simulation): a packet with X on the write_not_read bit is an error.

Optional Feature:
- Macro: BP_DMA_MEM_DELAY_EN.
- Defined:
  - After packet yumi, the FSM enters e_delay with a down-counter loaded to latency_p-1.
  - It moves to e_read/e_write when the counter reaches 0, so the first read beat is valid latency_p+1 cycles after yumi.
  - All outputs are 0 in e_delay.
- Undefined: no e_delay state and latency_p is unused; timing is as in Behaviour.

Test Plan:
- Write then read: pkt {1, 0x0000040}, beats 0x11..0x18 with v_i held high → yumi on 8 consecutive cycles; then pkt {0, 0x0000040} with ready = 1 → data_o 0x11..0x18 on 8 consecutive cycles, first beat the cycle after pkt yumi.
- Read backpressure: same read with ready toggling 1,0,0,1,… → each beat held stable while ready = 0; exactly 8 transfers, in order; return to e_ready after the 8th.
- Alignment and alias (mem_els_p = 1024, 8-byte words): write to 0x0000058 → stored at entries 8..15; read of 0x0002040 (word 0x408 → entry 8) → same data.
- Gating: dma_data_v_i = 1 with no packet → dma_data_yumi_o stays 0 for 20 cycles; pkt_v_i asserted during a read burst → pkt yumi only in the cycle after the last beat.
- Reset mid-burst: reset_i asserted at beat 3 of a write → all outputs 0; the next read of that block returns the 3 new beats (0..2) followed by the prior contents.
- With BP_DMA_MEM_DELAY_EN, latency_p = 4: read pkt yumi at cycle T → dma_data_v_o first high at T+5; v_o = 0 at T+1..T+4.
